// File: rtl/vga_regs_pkg.sv
// Register map of the display peripheral and the writer's FSM state type.
package vga_regs_pkg;

    localparam logic [3:0] REG_BOUNDARY_1 = 4'h0;
    localparam logic [3:0] REG_BOUNDARY_2 = 4'h1;
    localparam logic [3:0] REG_BOUNDARY_3 = 4'h2;
    localparam logic [3:0] REG_BOUNDARY_4 = 4'h3;
    localparam logic [3:0] REG_SPRITE1_X  = 4'h4;
    localparam logic [3:0] REG_SPRITE1_Y  = 4'h5;
    localparam logic [3:0] REG_SPRITE1_IMG = 4'h6;
    localparam logic [3:0] REG_SPRITE2_X  = 4'h7;
    localparam logic [3:0] REG_SPRITE2_Y  = 4'h8;
    localparam logic [3:0] REG_SPRITE2_IMG = 4'h9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2
    } writer_state_t;

endpackage

// File: rtl/reg_fifo.sv
// Synchronous FIFO holding pending register updates; pointers carry an extra
// wrap bit so full and empty are distinguishable without a separate counter.
module reg_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 22
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [W-1:0]                 head
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign count = CW'(wr_ptr - rd_ptr);
    assign head  = mem[rd_ptr[IW-1:0]];

endmodule

// File: rtl/vga_reg_writer.sv
// Avalon-MM master that queues display register updates and only drains them
// during vertical blanking so boundaries and sprites never change mid-frame.
module vga_reg_writer
    import vga_regs_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AW-1:0]                in_addr,
    input  logic [DW-1:0]                in_data,
    input  logic                         vblank,
    output logic [AW-1:0]                address,
    output logic [DW-1:0]                writedata,
    output logic                         write,
    output logic                         chipselect,
    input  logic                         waitrequest,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         frame_done,
    output logic                         late,
    output logic                         overflow,
    input  logic                         clr_status
);

    localparam int unsigned FW = AW + DW;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    writer_state_t state;
    writer_state_t state_nxt;

    logic          vblank_q;
    logic          rise;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [FW-1:0] fifo_head;

    logic          write_nxt;
    logic [AW-1:0] address_nxt;
    logic [DW-1:0] writedata_nxt;
    logic          frame_done_nxt;
    logic          late_set;
    logic          late_nxt;
    logic          overflow_nxt;

    reg_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({in_addr, in_data}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    assign rise       = vblank && !vblank_q;
    assign pending    = fifo_count;
    assign chipselect = write;

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        write_nxt      = write;
        address_nxt    = address;
        writedata_nxt  = writedata;
        frame_done_nxt = 1'b0;
        fifo_pop       = 1'b0;
        late_set       = 1'b0;

        case (state)
            IDLE: begin
                if (rise) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!vblank || fifo_empty) begin
                    state_nxt      = IDLE;
                    frame_done_nxt = 1'b1;
                    late_set       = !fifo_empty;
                end else begin
                    state_nxt     = WRITE;
                    write_nxt     = 1'b1;
                    address_nxt   = fifo_head[FW-1:DW];
                    writedata_nxt = fifo_head[DW-1:0];
                end
            end
            WRITE: begin
                // In-flight write always completes, even if vblank has ended.
                if (!waitrequest) begin
                    fifo_pop  = 1'b1;
                    write_nxt = 1'b0;
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        late_nxt     = late_set ? 1'b1 : (clr_status ? 1'b0 : late);
        overflow_nxt = (in_valid && fifo_full) ? 1'b1 : (clr_status ? 1'b0 : overflow);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vblank_q   <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            frame_done <= 1'b0;
            late       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            vblank_q   <= vblank;
            write      <= write_nxt;
            address    <= address_nxt;
            writedata  <= writedata_nxt;
            frame_done <= frame_done_nxt;
            late       <= late_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_vga_reg_writer.sv
// Bench for vga_reg_writer: vector table, directed corner sequences and a
// randomized run against a queue-based scoreboard.
module tb_vga_reg_writer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned FW    = AW + DW;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          vblank;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic          write;
    logic          chipselect;
    logic          waitrequest;
    logic [CW-1:0] pending;
    logic          frame_done;
    logic          late;
    logic          overflow;
    logic          clr_status;

    int checks;
    int failures;

    vga_reg_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .vblank      (vblank),
        .address     (address),
        .writedata   (writedata),
        .write       (write),
        .chipselect  (chipselect),
        .waitrequest (waitrequest),
        .pending     (pending),
        .frame_done  (frame_done),
        .late        (late),
        .overflow    (overflow),
        .clr_status  (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed bus writes and frame_done pulses, as seen at each edge.
    logic [FW-1:0] obs[$];
    int            fd_cnt = 0;
    always @(posedge clk) begin
        if (write && !waitrequest) obs.push_back({address, writedata});
        if (frame_done) fd_cnt++;
    end

    typedef struct {
        logic          in_valid;
        logic [AW-1:0] in_addr;
        logic [DW-1:0] in_data;
        logic          vblank;
        logic          exp_write;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        int            exp_pending;
        logic          exp_fd;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_addr     = '0;
        in_data     = '0;
        vblank      = 1'b0;
        waitrequest = 1'b0;
        clr_status  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    int            base;
    int            fd_base;
    int            cnt;
    int            vb_left;
    logic          vb;
    logic          ovf_m;
    logic          do_push;
    logic          wr_pre;
    logic          vb_drv;
    logic [FW-1:0] exp_q[$];

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = '{1'b1, 6'h04, 16'h0140, 1'b0, 1'b0, 6'h00, 16'h0000, 1, 1'b0};
        tbl[1]  = '{1'b1, 6'h05, 16'h00F1, 1'b0, 1'b0, 6'h00, 16'h0000, 2, 1'b0};
        tbl[2]  = '{1'b1, 6'h06, 16'h0001, 1'b0, 1'b0, 6'h00, 16'h0000, 3, 1'b0};
        tbl[3]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 3, 1'b0};
        tbl[4]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b1, 6'h04, 16'h0140, 3, 1'b0};
        tbl[5]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 2, 1'b0};
        tbl[6]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b1, 6'h05, 16'h00F1, 2, 1'b0};
        tbl[7]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 1, 1'b0};
        tbl[8]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b1, 6'h06, 16'h0001, 1, 1'b0};
        tbl[9]  = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 0, 1'b0};
        tbl[10] = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 0, 1'b1};
        tbl[11] = '{1'b0, 6'h00, 16'h0000, 1'b1, 1'b0, 6'h00, 16'h0000, 0, 1'b0};
        tbl[12] = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 0, 1'b0};

        // Reset state
        do_reset();
        check("rst_write",      32'(write), 0);
        check("rst_chipselect", 32'(chipselect), 0);
        check("rst_address",    32'(address), 0);
        check("rst_writedata",  32'(writedata), 0);
        check("rst_pending",    32'(pending), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_late",       32'(late), 0);
        check("rst_overflow",   32'(overflow), 0);
        check("rst_in_ready",   32'(in_ready), 1);

        // Basic drain, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].in_valid;
            in_addr  = tbl[i].in_addr;
            in_data  = tbl[i].in_data;
            vblank   = tbl[i].vblank;
            tick();
            check($sformatf("tbl%0d_write", i), 32'(write), 32'(tbl[i].exp_write));
            check($sformatf("tbl%0d_cs", i), 32'(chipselect), 32'(tbl[i].exp_write));
            check($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].exp_pending));
            check($sformatf("tbl%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].exp_fd));
            if (tbl[i].exp_write) begin
                check($sformatf("tbl%0d_address", i), 32'(address), 32'(tbl[i].exp_addr));
                check($sformatf("tbl%0d_writedata", i), 32'(writedata), 32'(tbl[i].exp_data));
            end
        end
        check("basic_late", 32'(late), 0);

        // No tearing: pushes while vblank is low never reach the bus
        do_reset();
        wr_pre = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = (i % 10 == 0);
            in_addr  = AW'(i % 10);
            in_data  = DW'(16'h2000 + i);
            tick();
            if (write) wr_pre = 1'b1;
        end
        in_valid = 1'b0;
        check("notear_write_seen", 32'(wr_pre), 0);
        check("notear_pending", 32'(pending), 10);

        // Backpressure holds the bus stable and does not pop
        do_reset();
        base = obs.size();
        push_one(6'h00, 16'hAAAA);
        push_one(6'h01, 16'h5555);
        waitrequest = 1'b1;
        vblank      = 1'b1;
        tick();
        tick();
        check("bp_write_up", 32'(write), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_write", i), 32'(write), 1);
            check($sformatf("bp_hold%0d_addr", i), 32'(address), 32'h0);
            check($sformatf("bp_hold%0d_data", i), 32'(writedata), 32'hAAAA);
            check($sformatf("bp_hold%0d_pending", i), 32'(pending), 2);
        end
        waitrequest = 1'b0;
        tick();
        check("bp_release_write", 32'(write), 0);
        check("bp_release_pending", 32'(pending), 1);
        tick();
        check("bp_second_addr", 32'(address), 32'h1);
        tick();
        vblank = 1'b0;
        check("bp_done_pending", 32'(pending), 0);
        check("bp_obs_count", 32'(obs.size() - base), 2);
        if (obs.size() - base == 2) begin
            check("bp_obs0", 32'(obs[base]),     32'({6'h00, 16'hAAAA}));
            check("bp_obs1", 32'(obs[base + 1]), 32'({6'h01, 16'h5555}));
        end

        // Window too short: 4 writes fit in 8 cycles, remaining 6 are late
        do_reset();
        base    = obs.size();
        fd_base = fd_cnt;
        for (int i = 0; i < 10; i++) push_one(AW'(i % 10), DW'(16'h0100 + i));
        vblank = 1'b1;
        repeat (8) tick();
        vblank = 1'b0;
        repeat (3) tick();
        check("short_obs_count", 32'(obs.size() - base), 4);
        check("short_late", 32'(late), 1);
        check("short_pending", 32'(pending), 6);
        check("short_frame_done_cnt", 32'(fd_cnt - fd_base), 1);
        vblank = 1'b1;
        repeat (20) tick();
        vblank = 1'b0;
        repeat (3) tick();
        check("short2_obs_count", 32'(obs.size() - base), 10);
        check("short2_pending", 32'(pending), 0);
        check("short2_late_sticky", 32'(late), 1);
        check("short2_frame_done_cnt", 32'(fd_cnt - fd_base), 2);
        for (int i = 0; i < 10; i++) begin
            if (base + i < obs.size())
                check($sformatf("short_order%0d", i), 32'(obs[base + i]),
                      32'({AW'(i % 10), DW'(16'h0100 + i)}));
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("short_late_cleared", 32'(late), 0);

        // Full FIFO: extra push dropped, overflow sticky, set beats clear
        do_reset();
        base = obs.size();
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_addr = AW'(i % 10);
            in_data = DW'(16'h3000 + i);
            tick();
        end
        check("full_in_ready", 32'(in_ready), 0);
        check("full_overflow_pre", 32'(overflow), 0);
        check("full_pending", 32'(pending), DEPTH);
        in_data = 16'hDEAD;
        tick();
        check("full_overflow_set", 32'(overflow), 1);
        check("full_pending_hold", 32'(pending), DEPTH);
        clr_status = 1'b1;
        tick();
        check("full_set_beats_clr", 32'(overflow), 1);
        in_valid = 1'b0;
        tick();
        clr_status = 1'b0;
        check("full_overflow_clr", 32'(overflow), 0);
        vblank = 1'b1;
        repeat (2 * DEPTH + 4) tick();
        vblank = 1'b0;
        tick();
        check("full_obs_count", 32'(obs.size() - base), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < obs.size())
                check($sformatf("full_order%0d", i), 32'(obs[base + i]),
                      32'({AW'(i % 10), DW'(16'h3000 + i)}));
        end

        // Reset during WRITE clears outputs without a clock edge
        do_reset();
        push_one(6'h07, 16'h1234);
        push_one(6'h08, 16'h5678);
        waitrequest = 1'b1;
        vblank      = 1'b1;
        tick();
        tick();
        check("mid_write_up", 32'(write), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(write), 0);
        check("mid_rst_cs", 32'(chipselect), 0);
        check("mid_rst_pending", 32'(pending), 0);
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("mid_post_pending", 32'(pending), 0);
        check("mid_post_in_ready", 32'(in_ready), 1);

        // Randomized run against an order-preserving scoreboard
        do_reset();
        cnt     = 0;
        ovf_m   = 1'b0;
        vb      = 1'b0;
        vb_left = 10;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (vb_left == 0) begin
                vb      = !vb;
                vb_left = vb ? int'($urandom_range(2, 20)) : int'($urandom_range(5, 40));
            end
            vb_left--;
            vblank      = vb;
            in_valid    = 1'($urandom_range(0, 1));
            in_addr     = AW'($urandom_range(0, 9));
            in_data     = DW'($urandom);
            waitrequest = ($urandom_range(0, 3) == 0);
            clr_status  = ($urandom_range(0, 15) == 0);

            do_push = in_valid && (cnt < DEPTH);
            if (write && !waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_pop: write 0x%0h completed with empty scoreboard at %0t",
                             {address, writedata}, $time);
                end else begin
                    check("rnd_write", 32'({address, writedata}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    cnt--;
                end
            end
            if (do_push) begin
                exp_q.push_back({in_addr, in_data});
                cnt++;
            end
            if (in_valid && !do_push) ovf_m = 1'b1;
            else if (clr_status)      ovf_m = 1'b0;
            wr_pre = write;
            vb_drv = vblank;

            tick();
            check("rnd_pending", 32'(pending), 32'(cnt));
            check("rnd_in_ready", 32'(in_ready), 32'(cnt < DEPTH));
            check("rnd_overflow", 32'(overflow), 32'(ovf_m));
            check("rnd_cs", 32'(chipselect), 32'(write));
            if (write && !wr_pre) check("rnd_start_in_vblank", 32'(vb_drv), 1);
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
